// File: rtl/simd_pc_file.sv
// simd_pc_file: per-SIMD program-counter and run-state file for resident wavefronts
module simd_pc_file #(
   parameter int PC_WIDTH  = 32,
   parameter int NUM_WAVES = 8,
   parameter int PC_STEP   = 1,
   parameter int WID_W     = $clog2(NUM_WAVES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WID_W-1:0]     active_context,
   input  logic                 dispatch,
   input  logic [WID_W-1:0]     dispatch_wave,
   input  logic [PC_WIDTH-1:0]  dispatch_pc,
   input  logic                 advance,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   input  logic                 halt,
   output logic [PC_WIDTH-1:0]  pc_out,
   output logic                 pc_valid,
   output logic [NUM_WAVES-1:0] wave_running,
   output logic [NUM_WAVES-1:0] wave_done,
   output logic                 dispatch_err
);
   logic [PC_WIDTH-1:0]  pc     [NUM_WAVES];
   logic [PC_WIDTH-1:0]  pc_nxt [NUM_WAVES];
   logic [NUM_WAVES-1:0] run_nxt, done_nxt;
   logic [PC_WIDTH-1:0]  pc_sel;
   logic                 val_sel, err_nxt;
   // Out-of-range wave ids match no loop index, so they are ignored and select zeros.
   always_comb begin
      run_nxt  = wave_running;
      done_nxt = wave_done;
      pc_sel   = '0;
      val_sel  = 1'b0;
      err_nxt  = 1'b0;
      for (int i = 0; i < NUM_WAVES; i++) begin
         pc_nxt[i] = pc[i];
         if (dispatch && int'(dispatch_wave) == i) begin
            pc_nxt[i]   = dispatch_pc;
            run_nxt[i]  = 1'b1;
            done_nxt[i] = 1'b0;
            err_nxt     = wave_running[i];
         end else if (int'(active_context) == i && wave_running[i]) begin
            run_nxt[i]  = ~halt;
            done_nxt[i] = halt;
            pc_nxt[i]   = (halt || !advance) ? pc[i] :
                          branch_taken ? branch_target : pc[i] + PC_WIDTH'(PC_STEP);
         end
      end
      for (int i = 0; i < NUM_WAVES; i++) begin
         if (int'(active_context) == i) begin
            pc_sel  = pc_nxt[i];
            val_sel = run_nxt[i];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= '{default: '0};
         wave_running <= '0;
         wave_done    <= '0;
         pc_out       <= '0;
         pc_valid     <= 1'b0;
         dispatch_err <= 1'b0;
      end else begin
         pc           <= pc_nxt;
         wave_running <= run_nxt;
         wave_done    <= done_nxt;
         pc_out       <= pc_sel;
         pc_valid     <= val_sel;
         dispatch_err <= err_nxt;
      end
   end
endmodule

// File: tb/tb_simd_pc_file.sv
// tb_simd_pc_file: directed checks of the PC file, plus 8-bit and 6-wave variants
module tb_simd_pc_file;
  logic        clk = 0;
  logic        rst = 0;
  logic [2:0]  active_context = 0;
  logic        dispatch = 0;
  logic [2:0]  dispatch_wave = 0;
  logic [31:0] dispatch_pc = 0;
  logic        advance = 0;
  logic        branch_taken = 0;
  logic [31:0] branch_target = 0;
  logic        halt = 0;
  logic [31:0] pc_out;
  logic        pc_valid, dispatch_err;
  logic [7:0]  wave_running, wave_done;
  logic [7:0]  pc_out8, run8, done8;
  logic        valid8, err8;
  logic [31:0] pc_out6;
  logic [5:0]  run6, done6;
  logic        valid6, err6;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  simd_pc_file dut (
    .clk(clk), .rst(rst), .active_context(active_context), .dispatch(dispatch),
    .dispatch_wave(dispatch_wave), .dispatch_pc(dispatch_pc), .advance(advance),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .pc_out(pc_out), .pc_valid(pc_valid), .wave_running(wave_running),
    .wave_done(wave_done), .dispatch_err(dispatch_err));
  simd_pc_file #(.PC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .active_context(active_context), .dispatch(dispatch),
    .dispatch_wave(dispatch_wave), .dispatch_pc(dispatch_pc[7:0]), .advance(advance),
    .branch_taken(branch_taken), .branch_target(branch_target[7:0]), .halt(halt),
    .pc_out(pc_out8), .pc_valid(valid8), .wave_running(run8),
    .wave_done(done8), .dispatch_err(err8));
  simd_pc_file #(.NUM_WAVES(6)) dut6 (
    .clk(clk), .rst(rst), .active_context(active_context), .dispatch(dispatch),
    .dispatch_wave(dispatch_wave), .dispatch_pc(dispatch_pc), .advance(advance),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .pc_out(pc_out6), .pc_valid(valid6), .wave_running(run6),
    .wave_done(done6), .dispatch_err(err6));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    dispatch = 0; advance = 0; branch_taken = 0; halt = 0;
  endtask
  task automatic disp(input logic [2:0] w, input logic [31:0] p);
    dispatch = 1; dispatch_wave = w; dispatch_pc = p;
  endtask
  initial begin
    rst = 1; tick; rst = 0;
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_valid", pc_valid, 1'b0);
    chk("rst_run", wave_running, 8'h00);
    chk("rst_done", wave_done, 8'h00);
    chk("rst_err", dispatch_err, 1'b0);
    active_context = 2; disp(2, 32'h100); tick;
    chk("w2_disp_pc", pc_out, 32'h100);
    chk("w2_disp_valid", pc_valid, 1'b1);
    chk("w2_disp_run", wave_running, 8'b0000_0100);
    advance = 1; tick;
    chk("w2_adv1", pc_out, 32'h101);
    advance = 1; tick;
    chk("w2_adv2", pc_out, 32'h102);
    advance = 1; tick;
    chk("w2_adv3", pc_out, 32'h103);
    chk("w2_valid", pc_valid, 1'b1);
    active_context = 0; disp(0, 32'h10); tick;
    chk("w0_disp", pc_out, 32'h10);
    advance = 1; branch_taken = 1; branch_target = 32'h40; tick;
    chk("w0_branch", pc_out, 32'h40);
    advance = 1; tick;
    chk("w0_adv", pc_out, 32'h41);
    branch_taken = 1; branch_target = 32'h80; tick;
    chk("w0_lone_branch", pc_out, 32'h41);
    active_context = 1; disp(1, 32'h1E); tick;
    chk("w1_disp", pc_out, 32'h1E);
    disp(3, 32'h300); tick;
    chk("w3_disp_other", pc_out, 32'h1E);
    chk("w13_run", wave_running, 8'h0F);
    advance = 1; tick;
    advance = 1; tick;
    chk("w1_adv2", pc_out, 32'h20);
    active_context = 3; advance = 1; tick;
    chk("w3_adv1", pc_out, 32'h301);
    active_context = 1; tick;
    chk("w1_resume", pc_out, 32'h20);
    active_context = 3; tick;
    chk("w3_hold", pc_out, 32'h301);
    active_context = 1; halt = 1; advance = 1; tick;
    chk("halt_pc", pc_out, 32'h20);
    chk("halt_valid", pc_valid, 1'b0);
    chk("halt_done", wave_done, 8'h02);
    chk("halt_run", wave_running, 8'h0D);
    advance = 1; tick;
    chk("done_adv_ignored", pc_out, 32'h20);
    disp(1, 32'h0); tick;
    chk("redisp_pc", pc_out, 32'h0);
    chk("redisp_valid", pc_valid, 1'b1);
    chk("redisp_done", wave_done, 8'h00);
    chk("redisp_err", dispatch_err, 1'b0);
    active_context = 4; disp(4, 32'h50); tick;
    chk("w4_disp", pc_out, 32'h50);
    disp(4, 32'h200); advance = 1; tick;
    chk("w4_clash_pc", pc_out, 32'h200);
    chk("w4_clash_err", dispatch_err, 1'b1);
    tick;
    chk("err_pulse_drop", dispatch_err, 1'b0);
    disp(4, 32'h50); tick;
    chk("w4_restart_err", dispatch_err, 1'b1);
    disp(5, 32'h200); advance = 1; tick;
    chk("w4_adv_with_w5", pc_out, 32'h51);
    chk("w5_err", dispatch_err, 1'b0);
    chk("w5_run", wave_running, 8'h3F);
    active_context = 5; tick;
    chk("w5_pc", pc_out, 32'h200);
    chk("w5_valid", pc_valid, 1'b1);
    active_context = 6; advance = 1; tick;
    chk("w6_idle_pc", pc_out, 32'h0);
    chk("w6_idle_valid", pc_valid, 1'b0);
    chk("oor6_pc", pc_out6, 32'h0);
    disp(6, 32'h77); tick;
    chk("w6_disp", pc_out, 32'h77);
    chk("w6_run", wave_running, 8'h7F);
    chk("oor6_disp_pc", pc_out6, 32'h0);
    chk("oor6_disp_valid", valid6, 1'b0);
    chk("oor6_run", run6, 6'h3F);
    disp(6, 32'h78); tick;
    chk("w6_redisp_err", dispatch_err, 1'b1);
    chk("oor6_no_err", err6, 1'b0);
    active_context = 7; disp(7, 32'hFF); tick;
    chk("w8_disp", pc_out8, 8'hFF);
    advance = 1; tick;
    chk("w8_wrap", pc_out8, 8'h00);
    chk("w32_nowrap", pc_out, 32'h100);
    rst = 1; advance = 1; tick; rst = 0;
    chk("mid_rst_pc", pc_out, 32'h0);
    chk("mid_rst_valid", pc_valid, 1'b0);
    chk("mid_rst_run", wave_running, 8'h00);
    chk("mid_rst_done", wave_done, 8'h00);
    chk("mid_rst_err", dispatch_err, 1'b0);
    active_context = 2; advance = 1; tick;
    chk("post_rst_pc", pc_out, 32'h0);
    chk("post_rst_valid", pc_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simd_pc_file.md
# simd_pc_file

Per-SIMD program-counter file that tracks one PC and one run state for each resident wavefront. It supports dispatch with an arbitrary start address, sequential advance, uniform (non-divergent) branch, and halt. It presents the registered PC of the currently scheduled wave to instruction fetch. It sits between the wave scheduler, which drives the context select and dispatch, and the fetch/decode stage, which drives advance, branch and halt.

## Interface
Parameters:
- PC_WIDTH, 32, width of every PC value
- NUM_WAVES, 8, resident wave contexts per SIMD unit (≥2)
- PC_STEP, 1, increment applied on sequential advance
- WID_W, $clog2(NUM_WAVES), width of wave-id fields

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- active_context  in  WID_W  wave currently scheduled; selects pc_out and the target of advance/branch/halt
- dispatch  in  1  start a wave in context dispatch_wave
- dispatch_wave  in  WID_W  context being (re)started
- dispatch_pc  in  PC_WIDTH  start address for the dispatched wave
- advance  in  1  active wave completed an instruction; PC += PC_STEP
- branch_taken  in  1  qualifies advance: load branch_target instead of incrementing
- branch_target  in  PC_WIDTH  absolute branch destination
- halt  in  1  active wave executed end-of-program; mark DONE, PC frozen
- pc_out  out  PC_WIDTH  registered PC of active_context after this cycle's updates
- pc_valid  out  1  registered; active_context is RUNNING
- wave_running  out  NUM_WAVES  registered bitmask, bit i = context i RUNNING
- wave_done  out  NUM_WAVES  registered bitmask, bit i = context i DONE
- dispatch_err  out  1  one-cycle registered pulse: dispatch targeted a RUNNING context

## Operation
- Per context: pc[i] (PC_WIDTH), state[i] ∈ {IDLE, RUNNING, DONE}.
- Transitions:
  - IDLE/DONE --dispatch--> RUNNING
  - RUNNING --halt--> DONE
  - RUNNING --dispatch--> RUNNING (restart at dispatch_pc, dispatch_err=1)
  - No other transitions.
- Dispatch: pc[dispatch_wave] ← dispatch_pc and state ← RUNNING, regardless of prior state.
- advance, halt and branch_taken act only on active_context, and only when state[active_context] == RUNNING. They are otherwise ignored with no state change.
- Priority on the active context: halt > advance&branch_taken > advance.
  - halt: state ← DONE, pc unchanged. Any advance in the same cycle is discarded.
  - branch_taken without advance is ignored.
- Arithmetic: pc + PC_STEP truncated to PC_WIDTH; wraps modulo 2^PC_WIDTH with no flag.
- Simultaneous dispatch and active-context update:
  - If dispatch_wave ≠ active_context, both take effect in the same cycle.
  - If dispatch_wave == active_context, dispatch wins. The PC becomes dispatch_pc, and advance/branch/halt are dropped.
- active_context ≥ NUM_WAVES (non-power-of-2 NUM_WAVES):
  - advance/branch/halt are ignored.
  - Next cycle pc_out = 0 and pc_valid = 0.
- dispatch_wave ≥ NUM_WAVES: dispatch is ignored, with no error pulse.
- pc_out and pc_valid reflect the post-update value of the context selected by this cycle's active_context. This includes a same-cycle dispatch to that context.
- DONE contexts retain their final PC, and pc_out shows it with pc_valid = 0.

## Timing
- Reset, on the edge where rst = 1: all pc[i] = 0, all state = IDLE, pc_out = 0, pc_valid = 0, wave_running = 0, wave_done = 0, dispatch_err = 0.
  - rst overrides all other inputs that cycle.
  - Mid-run reset discards all contexts.
- Latency: one cycle from any input to all outputs.
  - Inputs sampled at edge N are visible on pc_out, masks and dispatch_err after edge N.
- Back-to-back advance every cycle is supported: pc_out increments by PC_STEP each cycle.
- Switching active_context with no other input: pc_out shows the new context's stored PC one cycle later. Stored PCs are unaffected by the switch.
- dispatch_err stays high for exactly one cycle per offending dispatch and does not stick.

## Test plan
- Reset, then dispatch wave 2 at 0x100 with active_context = 2, then advance for 3 cycles -> pc_out 0x100, 0x101, 0x102, 0x103; pc_valid = 1; wave_running = 8'b0000_0100.
- Wave 0 running at 0x10; advance+branch_taken with target 0x40, then advance -> pc_out 0x40, then 0x41. A lone branch_taken with no advance leaves pc_out at 0x41.
- Waves 1 and 3 both running. Advance wave 1 twice, switch active_context to 3, advance once, switch back to 1 -> wave 1 resumes at its start + 2, and wave 3 holds at its start + 1.
- Halt on wave 1 at 0x20 with advance also asserted -> wave_done[1] = 1, wave_running[1] = 0, pc_out stays 0x20, pc_valid = 0. Further advance is ignored. A new dispatch at 0x0 restarts it with wave_done[1] = 0.
- Same cycle: dispatch wave 4 at 0x200 and advance on active wave 4 (running at 0x50) -> pc_out = 0x200 and dispatch_err = 1 for one cycle. Repeat with dispatch wave 5 instead -> wave 4 reaches 0x51 and wave 5 is RUNNING at 0x200.
- PC_WIDTH = 8, wave at 0xFF, advance -> pc_out = 0x00. Assert rst mid-run -> all outputs 0 on the next cycle.
